seq_chunk_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor for WIDTH-bit operands.
- Processes CHUNK bits per clock, ripple-chaining the carry through a register, so wide adds close timing with a small combinational adder.
- Sits between operand producers and result consumers, with valid/ready handshakes on both sides.
- Adds a subtract mode and signed-overflow detection to the basic carry-out.

---
 rtl/seq_chunk_adder_pkg.sv | 21 ++
 rtl/seq_chunk_adder_if.sv | 30 +++
 rtl/seq_chunk_adder_add_chunk.sv | 15 +
 rtl/seq_chunk_adder.sv | 108 ++++++++++
 tb/tb_seq_chunk_adder.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared constants and helpers for the chunked sequential adder.
package seq_chunk_adder_pkg;

  // Controller states, kept as plain two-bit codes so the encoding is fixed
  // and visible in waveforms and downstream tools.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Number of CHUNK-bit slices in a WIDTH-bit operand.
  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Width of the chunk index counter; never narrower than one bit so the
  // single-chunk configuration still has a legal register.
  function automatic int calc_idx_width(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle between producers, the adder and consumers.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer/consumer side.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/seq_chunk_adder_add_chunk.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
module seq_chunk_adder_add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  // Widen by one bit so the carry falls out of the top of the sum.
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that processes CHUNK bits per clock,
// carrying between slices through a register.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_chunk_adder_if.slave   bus
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IW     = calc_idx_width(NCHUNK);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // already inverted for subtract
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic             cout_q;
  logic             ovf_q;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_c;
  logic             last_chunk;
  logic             accept;
  logic             release_result;

  assign chunk_a        = a_q[idx_q*CHUNK +: CHUNK];
  assign chunk_b        = b_q[idx_q*CHUNK +: CHUNK];
  assign last_chunk     = (idx_q == IW'(NCHUNK - 1));
  assign accept         = bus.in_valid && (state == ST_IDLE);
  assign release_result = bus.out_ready && (state == ST_DONE);

  seq_chunk_adder_add_chunk #(
    .CHUNK (CHUNK)
  ) u_add_chunk (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry_q),
    .s    (chunk_s),
    .cout (chunk_c)
  );

  // Controller plus datapath registers: accept, ripple one slice per edge,
  // then hold the result until the consumer takes it.
  // NOTE: all registered state uses non-blocking assignment so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            sum_q   <= '0;
            idx_q   <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[idx_q*CHUNK +: CHUNK] <= chunk_s;
          carry_q                     <= chunk_c;
          if (last_chunk) begin
            cout_q <= chunk_c;
            // Signed overflow: operands agree in sign but the result does not.
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                      (chunk_s[CHUNK-1] != a_q[WIDTH-1]);
            idx_q  <= '0;
            state  <= ST_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_DONE: begin
          if (release_result) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench for seq_chunk_adder: a 16-bit/4-bit-chunk
// instance and a 16-bit single-cycle instance share the clock and reset.
module tb_seq_chunk_adder;

  logic clk;
  logic rst;

  // Shared stimulus; sel steers in_valid to one instance and picks which
  // instance's outputs are observed.
  logic        sel;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_ready;

  logic        obs_in_ready;
  logic        obs_out_valid;
  logic [15:0] obs_sum;
  logic        obs_cout;
  logic        obs_ovf;

  int checks;
  int errors;

  seq_chunk_adder_if #(.WIDTH(16)) bus0 ();
  seq_chunk_adder_if #(.WIDTH(16)) bus1 ();

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  assign bus0.in_valid  = in_valid & ~sel;
  assign bus0.a         = a;
  assign bus0.b         = b;
  assign bus0.cin       = cin;
  assign bus0.sub       = sub;
  assign bus0.out_ready = out_ready;

  assign bus1.in_valid  = in_valid & sel;
  assign bus1.a         = a;
  assign bus1.b         = b;
  assign bus1.cin       = cin;
  assign bus1.sub       = sub;
  assign bus1.out_ready = out_ready;

  assign obs_in_ready  = sel ? bus1.in_ready  : bus0.in_ready;
  assign obs_out_valid = sel ? bus1.out_valid : bus0.out_valid;
  assign obs_sum       = sel ? bus1.sum       : bus0.sum;
  assign obs_cout      = sel ? bus1.cout      : bus0.cout;
  assign obs_ovf       = sel ? bus1.ovf       : bus0.ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present operands at a falling edge and let the next rising edge accept them.
  task automatic start_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vcin, input logic vsub);
    @(negedge clk);
    a        = va;
    b        = vb;
    cin      = vcin;
    sub      = vsub;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(obs_in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count rising edges from the accept edge until out_valid, bounded.
  task automatic wait_result(input string tag, input int exp_lat, input logic [15:0] exp_sum,
                             input logic exp_cout, input logic exp_ovf);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!obs_out_valid && lat < 20);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_sum"}, 32'(obs_sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(obs_cout), 32'(exp_cout));
    check({tag, "_ovf"}, 32'(obs_ovf), 32'(exp_ovf));
  endtask

  // Hand the result to the consumer and confirm the return to idle.
  task automatic release_op(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_rel_out_valid"}, 32'(obs_out_valid), 32'd0);
    check({tag, "_rel_in_ready"}, 32'(obs_in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vcin, input logic vsub, input int exp_lat,
                        input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    start_op(tag, va, vb, vcin, vsub);
    wait_result(tag, exp_lat, exp_sum, exp_cout, exp_ovf);
    release_op(tag);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    sel       = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_sum", 32'(obs_sum), 32'd0);
    check("rst_cout", 32'(obs_cout), 32'd0);
    check("rst_ovf", 32'(obs_ovf), 32'd0);
    check("rst_out_valid", 32'(obs_out_valid), 32'd0);
    check("rst_in_ready", 32'(obs_in_ready), 32'd1);
    rst = 1'b0;

    // Basic add, carry rippling through every chunk, carry-in, overflow, subtract.
    run_op("t1", 16'h00FF, 16'h0001, 1'b0, 1'b0, 4, 16'h0100, 1'b0, 1'b0);
    run_op("t2a", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4, 16'h0000, 1'b1, 1'b0);
    run_op("t2b", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 4, 16'h0001, 1'b1, 1'b0);
    run_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 4, 16'h8000, 1'b0, 1'b1);
    run_op("t3b", 16'h0005, 16'h0007, 1'b1, 1'b1, 4, 16'hFFFE, 1'b0, 1'b0);

    // Backpressure: result held while new operands are offered and refused.
    start_op("t4", 16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_result("t4", 4, 16'h3333, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a        = 16'hFFFF;
      b        = 16'hFFFF;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("t4_hold_out_valid", 32'(obs_out_valid), 32'd1);
      check("t4_hold_sum", 32'(obs_sum), 32'h3333);
      check("t4_hold_cout", 32'(obs_cout), 32'd0);
      check("t4_hold_ovf", 32'(obs_ovf), 32'd0);
      check("t4_hold_in_ready", 32'(obs_in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_op("t4");

    // Asynchronous reset during the second RUN cycle aborts the operation.
    start_op("t5", 16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    check("t5_partial_sum", 32'(obs_sum), 32'h0005);
    rst = 1'b1;
    #1;
    check("t5_rst_sum", 32'(obs_sum), 32'd0);
    check("t5_rst_out_valid", 32'(obs_out_valid), 32'd0);
    check("t5_rst_in_ready", 32'(obs_in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t5_no_result", 32'(obs_out_valid), 32'd0);
    run_op("t5b", 16'h1234, 16'h1111, 1'b0, 1'b0, 4, 16'h2345, 1'b0, 1'b0);

    // Single-cycle instance: 0x8000 - 0x0001.
    @(negedge clk);
    sel = 1'b1;
    run_op("t6", 16'h8000, 16'h0001, 1'b0, 1'b1, 1, 16'h7FFF, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
